regfile_sb: RTL

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 129 ++++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
//------------------------------------------------------------------------------
// Module   : regfile_sb
// Purpose  : Two-read / one-write register file with a scoreboard. A busy
//            bit per register marks a pending producer: a claim sets it, a
//            write of the register clears it. busy_count tracks how many
//            registers are currently busy.
// Ports    : clock, ctrl_reset              - clock, synchronous active-high reset
//            ctrl_writeEnable/writeReg,
//            data_writeReg                 - write port
//            ctrl_readRegA/B               - read addresses
//            data_readRegA/B               - read data (combinational)
//            busy_readRegA/B               - busy flag of addressed register
//            ctrl_claimEnable/claimReg     - scoreboard claim port
//            busy_count                    - registered number of busy registers
// Options  : define REGFILE_BYPASS_EN to forward same-cycle write data (and
//            the resulting busy state) to a read port addressing the
//            register being written.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0] data_writeReg,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
  output logic [DATA_WIDTH-1:0] data_readRegA,
  output logic [DATA_WIDTH-1:0] data_readRegB,
  input  logic                  ctrl_claimEnable,
  input  logic [ADDR_WIDTH-1:0] ctrl_claimReg,
  output logic                  busy_readRegA,
  output logic                  busy_readRegB,
  output logic [ADDR_WIDTH:0]   busy_count
);

  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam bit HARD_ZERO = (ZERO_REG != 0);

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_next;
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH:0]   count_next;

  logic write_eff;
  logic claim_eff;
  logic count_inc;
  logic count_dec;

  logic [DATA_WIDTH-1:0] stored_a;
  logic [DATA_WIDTH-1:0] stored_b;

  // Register 0 ignores writes and claims when it is hardwired.
  assign write_eff = ctrl_writeEnable && !(HARD_ZERO && (ctrl_writeReg == '0));
  assign claim_eff = ctrl_claimEnable && !(HARD_ZERO && (ctrl_claimReg == '0));

  // Claim is applied after the write clear so that a same-register
  // claim+write leaves the register busy.
  always_comb begin
    busy_next = busy;
    if (write_eff) busy_next[ctrl_writeReg] = 1'b0;
    if (claim_eff) busy_next[ctrl_claimReg] = 1'b1;
  end

  // Incremental population count: at most one bit rises and one falls per
  // cycle, so the count moves by +1, -1 or 0 and cannot leave [0, DEPTH].
  always_comb begin
    count_inc  = claim_eff && !busy[ctrl_claimReg];
    count_dec  = write_eff && busy[ctrl_writeReg] &&
                 !(claim_eff && (ctrl_claimReg == ctrl_writeReg));
    count_next = count_q;
    if (count_inc && !count_dec)      count_next = count_q + 1'b1;
    else if (count_dec && !count_inc) count_next = count_q - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy    <= '0;
      count_q <= '0;
    end else begin
      if (write_eff) regs[ctrl_writeReg] <= data_writeReg;
      busy    <= busy_next;
      count_q <= count_next;
    end
  end

  assign busy_count = count_q;

  always_comb begin
    stored_a = (HARD_ZERO && (ctrl_readRegA == '0)) ? '0 : regs[ctrl_readRegA];
    stored_b = (HARD_ZERO && (ctrl_readRegB == '0)) ? '0 : regs[ctrl_readRegB];
  end

`ifdef REGFILE_BYPASS_EN
  logic hit_a;
  logic hit_b;

  // A hit shows the state the register will hold after this edge.
  assign hit_a = write_eff && (ctrl_writeReg == ctrl_readRegA);
  assign hit_b = write_eff && (ctrl_writeReg == ctrl_readRegB);

  always_comb begin
    data_readRegA = hit_a ? data_writeReg : stored_a;
    data_readRegB = hit_b ? data_writeReg : stored_b;
    busy_readRegA = hit_a ? (claim_eff && (ctrl_claimReg == ctrl_readRegA))
                          : busy[ctrl_readRegA];
    busy_readRegB = hit_b ? (claim_eff && (ctrl_claimReg == ctrl_readRegB))
                          : busy[ctrl_readRegB];
  end
`else
  always_comb begin
    data_readRegA = stored_a;
    data_readRegB = stored_b;
    busy_readRegA = busy[ctrl_readRegA];
    busy_readRegB = busy[ctrl_readRegB];
  end
`endif

endmodule

`default_nettype wire
